// File: rtl/vga_scene_sequencer.sv
// Frame-rate scene sequencer: vsync frame detect, animation counter, fade FSM.
// Optional pause/single-step support is compiled in with SEQ_PAUSE_EN.
module vga_scene_sequencer #(
    parameter int CNT_W       = 10,
    parameter int SCENE_W     = 2,
    parameter int NUM_SCENES  = 4,
    parameter int HOLD_FRAMES = 120,
    parameter int FADE_DIV    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               enable,
    input  logic               pause,
    input  logic               step,
    output logic               frame_tick,
    output logic [CNT_W-1:0]   anim_counter,
    output logic [SCENE_W-1:0] scene,
    output logic [1:0]         brightness,
    output logic [1:0]         seq_state
);

    localparam int SUB_MAX = (HOLD_FRAMES > FADE_DIV) ? HOLD_FRAMES : FADE_DIV;
    localparam int SUB_W   = (SUB_MAX > 1) ? $clog2(SUB_MAX) : 1;

    localparam logic [SUB_W-1:0]   FADE_LAST  = SUB_W'(FADE_DIV - 1);
    localparam logic [SUB_W-1:0]   HOLD_LAST  = SUB_W'(HOLD_FRAMES - 1);
    localparam logic [SCENE_W-1:0] SCENE_LAST = SCENE_W'(NUM_SCENES - 1);

    typedef enum logic [1:0] {
        BLACK    = 2'd0,
        FADE_IN  = 2'd1,
        HOLD     = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [1:0]         bright_q, bright_d;
    logic [SCENE_W-1:0] scene_q, scene_d;
    logic [CNT_W-1:0]   anim_q, anim_d;
    logic               vsync_q;
    logic               tick;
    logic               advance;

    assign tick = vsync & ~vsync_q;

`ifdef SEQ_PAUSE_EN
    logic step_q;
    logic step_pend;
    logic step_set;
    logic step_use;

    // A pending step lets exactly one paused tick through.
    assign step_set = step & ~step_q & pause;
    assign step_use = tick & enable & pause & step_pend;
    assign advance  = tick & enable & (~pause | step_pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q <= step;
            if (step_set)
                step_pend <= 1'b1;
            else if (step_use)
                step_pend <= 1'b0;
        end
    end
`else
    logic unused_pause_pins;

    assign unused_pause_pins = pause ^ step;
    assign advance = tick & enable;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            frame_tick <= 1'b0;
            state_q    <= BLACK;
            sub_q      <= '0;
            bright_q   <= 2'd0;
            scene_q    <= '0;
            anim_q     <= '0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= tick;
            state_q    <= state_d;
            sub_q      <= sub_d;
            bright_q   <= bright_d;
            scene_q    <= scene_d;
            anim_q     <= anim_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sub_d    = sub_q;
        bright_d = bright_q;
        scene_d  = scene_q;
        anim_d   = anim_q;
        if (advance) begin
            anim_d = anim_q + 1'b1;
            unique case (state_q)
                BLACK: begin
                    state_d = FADE_IN;
                    sub_d   = '0;
                end
                FADE_IN: begin
                    if (sub_q == FADE_LAST) begin
                        sub_d = '0;
                        if (bright_q != 2'd3)
                            bright_d = bright_q + 2'd1;
                        if (bright_q >= 2'd2)
                            state_d = HOLD;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (sub_q == HOLD_LAST) begin
                        sub_d   = '0;
                        state_d = FADE_OUT;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (sub_q == FADE_LAST) begin
                        sub_d = '0;
                        if (bright_q != 2'd0)
                            bright_d = bright_q - 2'd1;
                        // Scene changes as the fade bottoms out.
                        if (bright_q <= 2'd1) begin
                            state_d = FADE_IN;
                            scene_d = (scene_q == SCENE_LAST) ? '0
                                                              : scene_q + 1'b1;
                        end
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                default: state_d = BLACK;
            endcase
        end
    end

    assign anim_counter = anim_q;
    assign scene        = scene_q;
    assign brightness   = bright_q;
    assign seq_state    = state_q;

endmodule
